uart_tx_scheduler: RTL and testbench

//  Shares the UART transmitter between two requesters: the ALU (2-byte result) and the

---
 rtl/uart_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between the ALU (2-byte result, LSB first)
// and the register file (1 byte), sequenced through the DATA_VALID / Busy handshake.
module uart_tx_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int START_TO   = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ALU_REQ,
   input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
   output logic                    ALU_ACK,
   input  logic                    RF_REQ,
   input  logic [DATA_WIDTH-1:0]   RF_DATA,
   output logic                    RF_ACK,
   input  logic                    TX_BUSY,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    SCH_BUSY
);

   localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;
   localparam logic [TW-1:0] TMR_MAX = TW'(START_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      ISSUE,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [2*DATA_WIDTH-1:0]   shadow_q, shadow_d;
   logic [DATA_WIDTH-1:0]     txd_q, txd_d;
   logic [1:0]                left_q, left_d;
   logic [TW-1:0]             tmr_q, tmr_d;
   logic                      rr_q, rr_d;
   logic                      alu_win;

   always_comb begin
      // rr_q=1 means the register file was served last, so the ALU wins a tie
      alu_win   = ALU_REQ & (~RF_REQ | rr_q);
      state_d   = state_q;
      shadow_d  = shadow_q;
      txd_d     = txd_q;
      left_d    = left_q;
      tmr_d     = tmr_q;
      rr_d      = rr_q;
      ALU_ACK   = 1'b0;
      RF_ACK    = 1'b0;
      TX_D_VLD  = 1'b0;
      TX_P_DATA = txd_q;

      case (state_q)
         IDLE: begin
            if (ALU_REQ | RF_REQ) state_d = GRANT;
         end
         GRANT: begin
            if (ALU_REQ | RF_REQ) begin
               ALU_ACK  = alu_win;
               RF_ACK   = ~alu_win;
               shadow_d = alu_win ? ALU_DATA : {{DATA_WIDTH{1'b0}}, RF_DATA};
               left_d   = alu_win ? 2'd2 : 2'd1;
               rr_d     = ~alu_win;
               state_d  = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (!TX_BUSY) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = shadow_q[DATA_WIDTH-1:0];
               txd_d     = shadow_q[DATA_WIDTH-1:0];
               tmr_d     = '0;
               state_d   = WAIT_START;
            end
         end
         WAIT_START: begin
            // Timer stops at its maximum, so it never wraps while waiting
            if (TX_BUSY) begin
               state_d = WAIT_DONE;
            end else if (tmr_q >= TMR_MAX) begin
               state_d = ISSUE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!TX_BUSY) begin
               left_d = left_q - 2'd1;
               if (left_q == 2'd1) begin
                  state_d = IDLE;
               end else begin
                  shadow_d = shadow_q >> DATA_WIDTH;
                  state_d  = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (RST) begin
         ALU_ACK   = 1'b0;
         RF_ACK    = 1'b0;
         TX_D_VLD  = 1'b0;
         TX_P_DATA = txd_q;
      end
   end

   assign SCH_BUSY = (state_q != IDLE) & ~RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         txd_q   <= '0;
         left_q  <= '0;
         tmr_q   <= '0;
         rr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         left_q  <= left_d;
         tmr_q   <= tmr_d;
         rr_q    <= rr_d;
      end
   end

   always_ff @(posedge CLK) begin
      shadow_q <= shadow_d;
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle tables, directed retry/reset sequences, and a
// randomized run checked against a transaction-level arbitration and byte-order model.
module tb_uart_tx_scheduler;

   localparam int DW = 8;
   localparam int TO = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          ALU_REQ = 1'b0;
   logic [15:0]   ALU_DATA = '0;
   logic          RF_REQ = 1'b0;
   logic [7:0]    RF_DATA = '0;
   logic          TX_BUSY = 1'b0;
   logic          ALU_ACK, RF_ACK, TX_D_VLD, SCH_BUSY;
   logic [7:0]    TX_P_DATA;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   uart_tx_scheduler #(.DATA_WIDTH(DW), .START_TO(TO)) dut (
      .CLK(CLK), .RST(RST),
      .ALU_REQ(ALU_REQ), .ALU_DATA(ALU_DATA), .ALU_ACK(ALU_ACK),
      .RF_REQ(RF_REQ), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
      .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .SCH_BUSY(SCH_BUSY)
   );

   typedef struct {
      logic        alu_req;
      logic [15:0] alu_data;
      logic        rf_req;
      logic [7:0]  rf_data;
      logic        busy;
      logic [11:0] exp;
   } vec_t;

   vec_t tv[$];

   // Reference model state
   logic [7:0] exp_q[$];
   int         grant_log[$];
   logic       rr_last_m = 1'b1;
   logic       alu_acked = 1'b0, rf_acked = 1'b0;
   int         alu_gap = 0, rf_gap = 0;
   int         rise_in = 0, busy_left = 0;
   logic       gen_en = 1'b0, hold_mode = 1'b0;

   function automatic logic [11:0] o(input logic a, input logic r, input logic v,
                                     input logic s, input logic [7:0] pd);
      return {a, r, v, s, pd};
   endfunction

   function automatic logic [11:0] outs();
      return {ALU_ACK, RF_ACK, TX_D_VLD, SCH_BUSY, TX_P_DATA};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic a, input logic r, input logic b);
      @(posedge CLK); #1;
      ALU_REQ = a; RF_REQ = r; TX_BUSY = b;
      @(negedge CLK);
   endtask

   // One cycle of randomized requesters, a UART Busy responder and the model checks
   task automatic tick();
      logic exp_alu;
      @(posedge CLK); #1;
      if (alu_acked) begin
         alu_acked = 1'b0;
         if (!hold_mode) begin ALU_REQ = 1'b0; alu_gap = $urandom_range(1, 6); end
      end else if (!ALU_REQ && gen_en) begin
         if (alu_gap > 0) alu_gap--;
         else begin ALU_REQ = 1'b1; ALU_DATA = 16'($urandom); end
      end
      if (rf_acked) begin
         rf_acked = 1'b0;
         if (!hold_mode) begin RF_REQ = 1'b0; rf_gap = $urandom_range(1, 6); end
      end else if (!RF_REQ && gen_en) begin
         if (rf_gap > 0) rf_gap--;
         else begin RF_REQ = 1'b1; RF_DATA = 8'($urandom); end
      end
      if (rise_in > 0) begin
         rise_in--;
         if (rise_in == 0) begin TX_BUSY = 1'b1; busy_left = $urandom_range(1, 5); end
      end else if (TX_BUSY) begin
         busy_left--;
         if (busy_left == 0) TX_BUSY = 1'b0;
      end
      @(negedge CLK);
      if (ALU_ACK || RF_ACK) begin
         chk("ack_has_req", 32'(ALU_REQ || RF_REQ), 32'd1);
         exp_alu = ALU_REQ && (!RF_REQ || rr_last_m);
         chk("ack_winner", {ALU_ACK, RF_ACK}, {exp_alu, !exp_alu});
         if (exp_alu) begin
            exp_q.push_back(ALU_DATA[7:0]);
            exp_q.push_back(ALU_DATA[15:8]);
            rr_last_m = 1'b0;
            grant_log.push_back(0);
         end else begin
            exp_q.push_back(RF_DATA);
            rr_last_m = 1'b1;
            grant_log.push_back(1);
         end
         alu_acked = ALU_ACK;
         rf_acked  = RF_ACK;
      end
      if (TX_D_VLD) begin
         chk("dvld_while_busy", 32'(TX_BUSY), 32'd0);
         chk("dvld_queue", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("dvld_byte", TX_P_DATA, exp_q.pop_front());
         rise_in = $urandom_range(1, 3);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((ALU_REQ || RF_REQ || SCH_BUSY || TX_BUSY || rise_in > 0) && n < 1000) begin
         tick();
         n++;
      end
      chk({name, "_timeout"}, 32'(n < 1000), 32'd1);
      chk({name, "_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ord;
      int n;

      // ALU word A55A, UART responsive
      tv.push_back('{1'b1, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,0,0,8'h00)});
      tv.push_back('{1'b1, 16'hA55A, 1'b0, 8'h00, 1'b0, o(1,0,0,1,8'h00)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,1,1,8'h5A)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b1, o(0,0,0,1,8'h5A)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b1, o(0,0,0,1,8'h5A)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,0,1,8'h5A)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,1,1,8'hA5)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b1, o(0,0,0,1,8'hA5)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,0,1,8'hA5)});
      tv.push_back('{1'b0, 16'hA55A, 1'b0, 8'h00, 1'b0, o(0,0,0,0,8'hA5)});
      // RF byte 3C while the UART is still busy
      tv.push_back('{1'b0, 16'h0000, 1'b1, 8'h3C, 1'b1, o(0,0,0,0,8'hA5)});
      tv.push_back('{1'b0, 16'h0000, 1'b1, 8'h3C, 1'b1, o(0,1,0,1,8'hA5)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b1, o(0,0,0,1,8'hA5)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b1, o(0,0,0,1,8'hA5)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b0, o(0,0,1,1,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b1, o(0,0,0,1,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b0, o(0,0,0,1,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h3C, 1'b0, o(0,0,0,0,8'h3C)});
      // RF request withdrawn before grant
      tv.push_back('{1'b0, 16'h0000, 1'b1, 8'h99, 1'b0, o(0,0,0,0,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h99, 1'b0, o(0,0,0,1,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h99, 1'b0, o(0,0,0,0,8'h3C)});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 8'h99, 1'b0, o(0,0,0,0,8'h3C)});

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_outputs", outs(), o(0,0,0,0,8'h00));

      for (int i = 0; i < tv.size(); i++) begin
         @(posedge CLK); #1;
         RST = 1'b0;
         ALU_REQ = tv[i].alu_req; ALU_DATA = tv[i].alu_data;
         RF_REQ = tv[i].rf_req;   RF_DATA = tv[i].rf_data;
         TX_BUSY = tv[i].busy;
         @(negedge CLK);
         chk($sformatf("vec%0d", i), outs(), tv[i].exp);
      end

      // Busy never rises: same byte re-pulsed every START_TO+1 cycles
      ALU_DATA = 16'h1234;
      cyc(1, 0, 0); chk("t4_idle", outs(), o(0,0,0,0,8'h3C));
      cyc(1, 0, 0); chk("t4_ack", outs(), o(1,0,0,1,8'h3C));
      cyc(0, 0, 0); chk("t4_pulse0", outs(), o(0,0,1,1,8'h34));
      for (int k = 1; k <= 12; k++) begin
         cyc(0, 0, 0);
         chk($sformatf("t4_retry%0d", k), outs(), o(0,0,(k % 5 == 0),1,8'h34));
      end
      cyc(0, 0, 1); chk("t4_busy", outs(), o(0,0,0,1,8'h34));
      cyc(0, 0, 0); chk("t4_done", outs(), o(0,0,0,1,8'h34));
      cyc(0, 0, 0); chk("t4_msb", outs(), o(0,0,1,1,8'h12));
      cyc(0, 0, 1); chk("t4_msb_busy", outs(), o(0,0,0,1,8'h12));
      cyc(0, 0, 0); chk("t4_msb_done", outs(), o(0,0,0,1,8'h12));
      cyc(0, 0, 0); chk("t4_idle_end", outs(), o(0,0,0,0,8'h12));

      // Reset during the LSB frame abandons the MSB
      ALU_DATA = 16'hBEEF;
      cyc(1, 0, 0); chk("t5_idle", outs(), o(0,0,0,0,8'h12));
      cyc(1, 0, 0); chk("t5_ack", outs(), o(1,0,0,1,8'h12));
      cyc(0, 0, 0); chk("t5_lsb", outs(), o(0,0,1,1,8'hEF));
      cyc(0, 0, 1); chk("t5_busy", outs(), o(0,0,0,1,8'hEF));
      cyc(0, 0, 1); chk("t5_wait_done", outs(), o(0,0,0,1,8'hEF));
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("t5_rst_cycle", {ALU_ACK, RF_ACK, TX_D_VLD}, 3'b000);
      @(posedge CLK); #1;
      RST = 1'b0; TX_BUSY = 1'b0;
      @(negedge CLK);
      chk("t5_after_rst", outs(), o(0,0,0,0,8'h00));
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0, 0);
         chk($sformatf("t5_quiet%0d", k), outs(), o(0,0,0,0,8'h00));
      end
      RF_DATA = 8'h77;
      cyc(0, 1, 0); chk("t5_rf_idle", outs(), o(0,0,0,0,8'h00));
      cyc(0, 1, 0); chk("t5_rf_ack", outs(), o(0,1,0,1,8'h00));
      cyc(0, 0, 0); chk("t5_rf_pulse", outs(), o(0,0,1,1,8'h77));
      cyc(0, 0, 1); chk("t5_rf_busy", outs(), o(0,0,0,1,8'h77));
      cyc(0, 0, 0); chk("t5_rf_done", outs(), o(0,0,0,1,8'h77));
      cyc(0, 0, 0); chk("t5_rf_idle_end", outs(), o(0,0,0,0,8'h77));

      // Both requesters held continuously: strict alternation starting with the ALU
      rr_last_m = 1'b1;
      ALU_DATA = 16'hA55A; RF_DATA = 8'h3C;
      ALU_REQ = 1'b1; RF_REQ = 1'b1;
      hold_mode = 1'b1;
      n = 0;
      while (grant_log.size() < 4 && n < 400) begin
         tick();
         n++;
      end
      chk("t2_grants", 32'(grant_log.size() >= 4), 32'd1);
      ord = '1;
      if (grant_log.size() >= 4)
         for (int i = 0; i < 4; i++) ord[3-i] = grant_log[i][0];
      chk("t2_order", ord, 4'b0101);
      hold_mode = 1'b0;
      tick();
      ALU_REQ = 1'b0;
      drain("t2_drain");

      // Randomized traffic
      grant_log.delete();
      gen_en = 1'b1;
      repeat (3000) tick();
      gen_en = 1'b0;
      drain("rand_drain");
      chk("rand_activity", 32'(grant_log.size() > 50), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
